direction_encoder: RTL and testbench

DIRECTION_ENCODER -- requirements
Module: direction_encoder

---
 rtl/direction_pkg.sv | 51 +++++
 rtl/debouncer.sv | 43 ++++
 rtl/direction_encoder.sv | 116 +++++++++++
 tb/tb_direction_encoder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/direction_pkg.sv
// rtl/direction_pkg.sv - shared direction/FSM encodings for the direction encoder and display
// Contents: dir_t command code, state_t FSM states, press_t button classification,
//           classify() and onehot_dir() helpers.
package direction_pkg;

  typedef enum logic [1:0] {
    FWD   = 2'b00,
    REV   = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PRESS_NONE   = 2'b00,
    PRESS_SINGLE = 2'b01,
    PRESS_MULTI  = 2'b10
  } press_t;

  // none = no bit set, single = exactly one bit set, multi = anything else
  function automatic press_t classify(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n = n + int'(v[i]);
    end
    if (n == 0) begin
      return PRESS_NONE;
    end else if (n == 1) begin
      return PRESS_SINGLE;
    end else begin
      return PRESS_MULTI;
    end
  endfunction

  // Only meaningful for a one-hot input; callers gate it with classify()
  function automatic dir_t onehot_dir(input logic [3:0] v);
    case (v)
      4'b0010: return REV;
      4'b0100: return LEFT;
      4'b1000: return RIGHT;
      default: return FWD;
    endcase
  endfunction

endpackage

// File: rtl/debouncer.sv
// rtl/debouncer.sv - two-flop synchroniser plus per-bit debounce counter
// Ports: clk, reset (async, active-high), btn (raw async button bit),
//        db (debounced, synchronised button level).
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive cycles where sync2 disagrees with db. On the
  // DEBOUNCE_CYCLES-th such cycle db flips and cnt returns to 0, so the
  // counter tops out at LAST and can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/direction_encoder.sv
// rtl/direction_encoder.sv - debounced 4-button to direction command encoder with hold-off
// Ports: clk, reset (async, active-high), btn[3:0] (fwd/rev/left/right, raw),
//        direc[1:0] (latched dir_t code), enable (command valid),
//        cmd_strobe (one-cycle pulse per newly latched command).
import direction_pkg::*;

module direction_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [1:0] direc,
  output logic       enable,
  output logic       cmd_strobe
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  logic [3:0]    db_vec;
  press_t        press;
  dir_t          press_dir;

  state_t        state;
  state_t        next_state;
  dir_t          direc_q;
  dir_t          next_direc;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] next_hold;
  logic          next_enable;
  logic          next_strobe;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[i]),
      .db   (db_vec[i])
    );
  end

  assign press     = classify(db_vec);
  assign press_dir = onehot_dir(db_vec);

  // State register; all outputs are registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      direc_q    <= FWD;
      hold_cnt   <= '0;
      enable     <= 1'b0;
      cmd_strobe <= 1'b0;
    end else begin
      state      <= next_state;
      direc_q    <= next_direc;
      hold_cnt   <= next_hold;
      enable     <= next_enable;
      cmd_strobe <= next_strobe;
    end
  end

  // Next-state logic. Multi-press never alters direc in any state.
  always_comb begin
    next_state = state;
    next_direc = direc_q;
    next_hold  = hold_cnt;
    case (state)
      IDLE: begin
        if (press == PRESS_SINGLE) begin
          next_state = ACTIVE;
          next_direc = press_dir;
        end
      end
      ACTIVE: begin
        if (press == PRESS_SINGLE) begin
          next_direc = press_dir;
        end else if (press == PRESS_NONE) begin
          next_state = HOLD;
          next_hold  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (press == PRESS_SINGLE) begin
          next_state = ACTIVE;
          next_direc = press_dir;
        end else if (hold_cnt == '0) begin
          next_state = IDLE;
        end else begin
          next_hold = hold_cnt - 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output logic. A strobe marks either a fresh command out of IDLE or a
  // change of the latched code; re-pressing the same button never strobes.
  always_comb begin
    next_enable = (next_state != IDLE);
    next_strobe = 1'b0;
    if (state == IDLE && next_state == ACTIVE) begin
      next_strobe = 1'b1;
    end else if (next_state == ACTIVE && next_direc != direc_q) begin
      next_strobe = 1'b1;
    end
  end

  assign direc = direc_q;

endmodule

// File: tb/tb_direction_encoder.sv
// tb/tb_direction_encoder.sv - directed self-checking bench for direction_encoder
module tb_direction_encoder;

  localparam int DB = 4;
  localparam int HC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic [1:0] direc;
  logic       enable;
  logic       cmd_strobe;

  int   checks = 0;
  int   errors = 0;
  logic prev_strobe = 1'b0;

  always #5 clk = ~clk;

  direction_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .direc     (direc),
    .enable    (enable),
    .cmd_strobe(cmd_strobe)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 ns after the edge and check the strobe invariants
  task automatic tick();
    @(posedge clk);
    #1;
    check("strobe_back_to_back", 4'(prev_strobe & cmd_strobe), 4'h0);
    check("strobe_without_enable", 4'(cmd_strobe & ~enable), 4'h0);
    prev_strobe = cmd_strobe;
  endtask

  task automatic quiet(input int n, input logic en, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_strobe"}, 4'(cmd_strobe), 4'h0);
      check({tag, "_enable"}, 4'(enable), 4'(en));
    end
  endtask

  // Button edge already applied; command must appear exactly 7 cycles later
  task automatic press_expect(input logic [1:0] d, input logic en_before, input string tag);
    quiet(6, en_before, {tag, "_latency"});
    tick();
    check({tag, "_strobe"}, 4'(cmd_strobe), 4'h1);
    check({tag, "_enable"}, 4'(enable), 4'h1);
    check({tag, "_direc"}, 4'(direc), 4'(d));
    tick();
    check({tag, "_strobe_end"}, 4'(cmd_strobe), 4'h0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    btn   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_direc", 4'(direc), 4'h0);
    check("reset_enable", 4'(enable), 4'h0);
    check("reset_strobe", 4'(cmd_strobe), 4'h0);
    reset = 1'b0;

    // Forward held 20 cycles, then released; enable lasts 8 cycles into HOLD
    btn = 4'b0001;
    press_expect(2'b00, 1'b0, "fwd");
    quiet(12, 1'b1, "fwd_held");
    btn = 4'b0000;
    quiet(14, 1'b1, "fwd_hold");
    tick();
    check("hold_expire_enable", 4'(enable), 4'h0);
    check("idle_direc_kept", 4'(direc), 4'h0);

    // Bouncing right button, then held
    for (int i = 0; i < 15; i++) begin
      btn[3] = ~btn[3];
      quiet(2, 1'b0, "bounce");
    end
    quiet(4, 1'b0, "right_settle");
    tick();
    check("right_strobe", 4'(cmd_strobe), 4'h1);
    check("right_enable", 4'(enable), 4'h1);
    check("right_direc", 4'(direc), 4'h3);

    // Switch to forward, then multi-press, then release to left
    btn = 4'b0001;
    press_expect(2'b00, 1'b1, "fwd2");
    btn = 4'b0101;
    quiet(10, 1'b1, "multi");
    check("multi_direc", 4'(direc), 4'h0);
    btn = 4'b0100;
    press_expect(2'b10, 1'b1, "left");

    // Forward, release into HOLD, re-press forward at hold count 3, then left
    btn = 4'b0001;
    press_expect(2'b00, 1'b1, "fwd3");
    btn = 4'b0000;
    quiet(5, 1'b1, "rel");
    btn = 4'b0001;
    quiet(7, 1'b1, "repress");
    check("repress_direc", 4'(direc), 4'h0);
    quiet(10, 1'b1, "repress_active");
    btn = 4'b0100;
    press_expect(2'b10, 1'b1, "left2");

    // Reset mid-ACTIVE with right held
    btn = 4'b1000;
    press_expect(2'b11, 1'b1, "right2");
    quiet(2, 1'b1, "right2_held");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_direc", 4'(direc), 4'h0);
    check("async_reset_enable", 4'(enable), 4'h0);
    check("async_reset_strobe", 4'(cmd_strobe), 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    prev_strobe = 1'b0;
    press_expect(2'b11, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
